// File: rtl/riscv_pkg.sv
// Shared types for the instruction-fetch slice: the fetch FSM states and the
// FIFO entry that pairs an instruction word with its byte PC.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Response buffer between instr_mem and decode. Shift-register organisation so
// the head entry is always slot 0, which makes the head output a plain flop.
// A clear in the same cycle as a push wins; the pushed word is discarded.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               clear,
    output fetch_entry_t       head,
    output logic               head_valid,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t           ent_q [DEPTH];
    fetch_entry_t           ent_d [DEPTH];
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       wr_idx;

    // Next storage contents: pop shifts toward the head, push lands behind the
    // last valid entry (one slot earlier when a pop happens in the same cycle).
    always_comb begin
        ent_d  = ent_q;
        cnt_d  = cnt_q;
        wr_idx = pop ? (cnt_q - CNT_W'(1)) : cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    ent_d[i] = ent_q[i + 1];
                end
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(wr_idx)) begin
                        ent_d[i] = push_entry;
                    end
                end
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign head       = ent_q[0];
    assign head_valid = (cnt_q != '0);
    assign count      = cnt_q;

    // The issue throttle upstream must never let the buffer overflow or underflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !clear && (cnt_q == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (cnt_q == '0)));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the synchronous instr_mem
// address, buffers returned words in fetch_fifo and presents them to decode
// over valid/ready. Redirects squash everything in flight or buffered.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_stall.
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter int          DATA_BITS = 32,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic [ADDR_BITS-1:0] imem_addr,
    input  logic [DATA_BITS-1:0] imem_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_instr,
    output logic [31:0]          out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [31:0]        inflight_pc_q, inflight_pc_d;

    logic               pop;
    logic               push;
    logic               issue;
    int                 occ;
    logic [CNT_W-1:0]   fifo_count;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    assign pop = out_valid && out_ready;

    // Issue throttle: count buffered words plus the one still in flight, minus
    // the one leaving this cycle, so a returning word always has a free slot.
    always_comb begin
        occ   = int'(fifo_count) + int'(inflight_q) - int'(pop);
        issue = (state_q == RUN) && !redirect_valid && (occ < BUF_DEPTH);
    end

    // Next-state, PC and in-flight tracking; a redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        if (redirect_valid) begin
            state_d = FLUSH;
            pc_d    = redirect_pc & ~32'h3;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            case (state_q)
                IDLE:    state_d = fetch_en ? RUN : IDLE;
                RUN:     state_d = fetch_en ? RUN : IDLE;
                FLUSH:   state_d = fetch_en ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers of the fetch FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign imem_addr = pc_q[ADDR_BITS+1:2];

    // The word returning in a redirect cycle belongs to the old path.
    assign push             = inflight_q && !redirect_valid;
    assign push_entry.instr = imem_data;
    assign push_entry.pc    = inflight_pc_q;

    fetch_fifo #(
        .DEPTH      (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .clear      (redirect_valid),
        .head       (head),
        .head_valid (out_valid),
        .count      (fifo_count)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Free-running event counts; redirects deliberately leave them alone.
    always_comb begin
        perf_fetched_d = perf_fetched_q + (pop ? 32'd1 : 32'd0);
        perf_stall_d   = perf_stall_q + ((out_valid && !out_ready) ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with a behavioural instr_mem (mem[i] = 0x1000_0000 + i).
// Reference: decode must see the architectural instruction stream in order --
// each accepted pc is the previous one + 4, or the redirect target -- and each
// instruction must equal the memory word for its pc.
module tb_fetch_ctrl;

    localparam int ADDR_BITS = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 fetch_en = 1'b0;
    logic                 redirect_valid = 1'b0;
    logic [31:0]          redirect_pc = '0;
    logic [ADDR_BITS-1:0] imem_addr;
    logic [31:0]          imem_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [31:0]          out_instr;
    logic [31:0]          out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]          perf_fetched;
    logic [31:0]          perf_stall;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 32'h0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    logic        nogap_en = 1'b0;
    logic        last_vld = 1'b0;
    logic [31:0] last_pc = '0;
    int          n_pop = 0;
    int          n_stall = 0;

    fetch_ctrl #(
        .ADDR_BITS      (ADDR_BITS),
        .DATA_BITS      (32),
        .RESET_PC       (32'h0),
        .BUF_DEPTH      (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) imem_data <= 32'h1000_0000 + 32'(imem_addr);

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h3FF);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: sample at the falling edge, score, then advance.
    task automatic step();
        @(negedge clk);
        if (out_valid) check("instr_of_pc", out_instr, instr_of(out_pc));
        if (prev_hold) begin
            check("hold_vld", 32'(out_valid), 32'd1);
            check("hold_pc", out_pc, prev_pc);
            check("hold_instr", out_instr, prev_instr);
        end
        if (nogap_en) check("nogap", 32'(out_valid), 32'd1);
        if (out_valid && out_ready) begin
            check("pop_pc", out_pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (out_valid && !out_ready) n_stall++;
        prev_hold  = out_valid && !out_ready && !redirect_valid;
        prev_pc    = out_pc;
        prev_instr = out_instr;
        last_vld   = out_valid;
        last_pc    = out_pc;
        if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_pc    = 32'h0;
        prev_hold = 1'b0;
        n_pop     = 0;
        n_stall   = 0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int i;
        i = 0;
        while (!last_vld && i < budget) begin
            step();
            i++;
        end
        check(tag, 32'(last_vld), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int lat;
        logic [ADDR_BITS-1:0] frozen;

        // 1: reset, stream from RESET_PC
        @(posedge clk);
        #1;
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        lat = 0;
        last_vld = 1'b0;
        while (!last_vld && lat < 8) begin
            step();
            if (!last_vld) lat++;
        end
        check("first_vld_lat", 32'((lat >= 2) && (lat <= 3)), 32'd1);
        nogap_en = 1'b1;
        for (int i = 0; i < 20; i++) step();
        nogap_en = 1'b0;

        // 2: decode stall at pc 0x10
        do_reset();
        for (int i = 0; i < 20 && exp_pc != 32'h10; i++) step();
        out_ready = 1'b0;
        frozen = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_vld", 32'(last_vld), 32'd1);
            check("stall_pc", last_pc, 32'h10);
            if (i == 1) frozen = imem_addr;
            if (i > 1) check("stall_addr", 32'(imem_addr), 32'(frozen));
        end
        out_ready = 1'b1;
        nogap_en  = 1'b1;
        for (int i = 0; i < 3; i++) step();
        nogap_en = 1'b0;
        check("release_pc", exp_pc, 32'h1C);

        // 3: redirect to 0x40 while streaming
        for (int i = 0; i < 4; i++) step();
        redirect(32'h40);
        step();
        check("flush_vld1", 32'(last_vld), 32'd0);
        step();
        check("flush_vld2", 32'(last_vld), 32'd0);
        wait_valid("redir_arrive", 2);
        check("redir_pc", last_pc, 32'h40);
        for (int i = 0; i < 4; i++) step();

        // 4: back-to-back redirects, the last one wins
        redirect(32'h43);
        redirect(32'h80);
        step();
        check("b2b_vld", 32'(last_vld), 32'd0);
        wait_valid("b2b_arrive", 4);
        check("b2b_pc", last_pc, 32'h80);
        for (int i = 0; i < 4; i++) step();

        // 5: word-index wrap and full 32-bit PC wrap
        redirect(32'hFF8);
        for (int i = 0; i < 8; i++) step();
        redirect(32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) step();

        // 6: fetch_en drop drains everything issued, then async reset mid-stream
        fetch_en = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("drain_vld", 32'(last_vld), 32'd0);
        check("drain_noloss", 32'(imem_addr), 32'(exp_pc[ADDR_BITS+1:2]));
        fetch_en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        do_reset();

        // 7: randomized traffic against the stream model
        for (int i = 0; i < 2000; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            step();
        end
        redirect_valid = 1'b0;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("rand_live", 32'(last_vld), 32'd1);

`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'(n_pop));
        check("perf_stall", perf_stall, 32'(n_stall));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
